tile_cl_resp_ring: RTL
======================

Name: tile_cl_resp_ring

Overview:
- Response-side ring stop for the tile XY mesh. Completions from the local memory slice are packed into response packets addressed to the requesting tile and injected onto one X-ring or Y-ring segment.
- Transit packets are forwarded; packets whose coordinate matches this stop are dropped into delivery queues.
- Matched packets are presented to the tile's response consumer.
- One instance per ring direction per tile, mirroring the request-side stop.

Parameters:
- TILE_X, 0, this tile's X coordinate (5 bits used)
- TILE_Y, 0, this tile's Y coordinate (5 bits used)
- IDX, 0, ring selector: 0/1 = X ring (compare TX), 2/3 = Y ring (compare TY)
- DEPTH, 8, entries per FIFO (power of two, ≥4)
- DATA_W, 528, response payload width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rsp_en  in  1  local response valid
- rsp_data  in  DATA_W  payload
- rsp_dst  in  10  destination {TY[4:0],TX[4:0]}
- rsp_addr  in  33  line address
- rsp_size  in  12  {shared,exclusive,phymsk}
- rsp_stall  out  1  injection register full; rsp_en ignored while high
- lnk_in_vld  in  [1:0]  packet valid from ring; lane0 from higher-coord neighbour, lane1 from lower
- lnk_in_pkt  in  [1:0][DATA_W+56:0]  {addr,sz,TY,TX,YDONE,XDONE,data}
- lnk_in_full  out  [1:0]  backpressure to upstream
- lnk_out_vld  out  [1:0]  lane0 toward lower coord, lane1 toward higher
- lnk_out_pkt  out  [1:0][DATA_W+56:0]  same format
- lnk_out_full  in  [1:0]  downstream backpressure
- dlv_vld  out  1  delivered response valid
- dlv_data  out  DATA_W  payload
- dlv_addr  out  43  {TILE_Y,TILE_X,addr}
- dlv_size  out  12  sz
- dlv_rdy  in  1  consumer accepts
- ovf_err  out  1  sticky overflow flag

Behaviour:
- Reset (rst=0, async): all FIFO pointers/counts and the injection register cleared. All outputs are 0: rsp_stall, lnk_out_vld, lnk_in_full, dlv_vld, ovf_err.
- Coordinate: c(pkt) = IDX<2 ? TX : TY. Own coordinate is k = IDX<2 ? TILE_X : TILE_Y.
- Injection:
  - rsp_en & ~rsp_stall captures the packet into the injection register at the next edge, so injection latency is one cycle minimum.
  - XDONE=(IDX<2) and YDONE=(IDX>=2) are set at capture.
  - rsp_stall = injection register valid and not consumed this cycle.
- Injection routing:
  - c>k uses lane1; c<k uses lane0.
  - c==k is loopback into delivery FIFO 0. It is consumed only if no lane0 match is written that cycle.
- Ring input on lane i with lnk_in_vld[i]:
  - c==k: write delivery FIFO i.
  - Otherwise: write pass-through FIFO i.
- Lane output i: the pass-through FIFO i head has strict priority over injection.
  - lnk_out_vld[i] = (head present or injection targets lane i) & ~lnk_out_full[i].
  - An entry is popped on the same edge that it is sent.
- Backpressure:
  - lnk_in_full[i] is registered. It is 1 when the pass-through count is ≥DEPTH-2 or the delivery count is ≥DEPTH-2.
  - This gives two slots of in-flight slack.
- Delivery:
  - Round-robin arbiter between delivery FIFOs 0 and 1. The pointer starts at 0 and advances past the granted FIFO on dlv_vld&dlv_rdy.
  - dlv_* is driven combinationally from the granted head, with no bubble between back-to-back pops.
  - dlv_addr = {TILE_Y,TILE_X,addr}.
- Simultaneous push and pop on one FIFO: count is unchanged, both pointers advance. This is legal when full.
- Push to a full FIFO is a protocol violation: the packet is dropped and ovf_err is set until reset.
- Pointers wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits wide.
- Reset asserted mid-transfer discards all queued packets. No partial output persists.

Test Plan:
- TILE_X=3, IDX=0, inject rsp_dst TX=7 at cycle 0 -> lnk_out_vld[1]=1 at cycle 1 with XDONE=1, YDONE=0; rsp_stall=0 at cycle 2.
- Ring lane0 delivers TX=3, data=0xA5, addr=0x1F0 with dlv_rdy=1 -> dlv_vld next cycle, dlv_addr={TILE_Y,5'd3,33'h1F0}, dlv_data=0xA5.
- Lane1 transit TX=9 and local injection TX=9 in the same cycle -> transit sent first, injection one cycle later; rsp_stall=1 for exactly one cycle.
- Hold lnk_out_full[1]=1, stream 6 transit packets on lane1 -> lnk_in_full[1] rises after the 6th (DEPTH=8). Release -> 6 packets sent in order, lnk_in_full[1] falls. ovf_err stays 0.
- Both delivery FIFOs hold 2 entries each, dlv_rdy=1 -> grant order 0,1,0,1.
- Fill pass-through FIFO 0 to 8 entries, drive one more lnk_in_vld[0] -> ovf_err=1 and stays 1. Then assert rst low mid-stream -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/tile_cl_resp_ring.sv
// Response-side ring stop: injects local completions onto one ring direction,
// forwards transit traffic and delivers packets addressed to this stop.
`default_nettype none

module tile_cl_resp_ring_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic [$clog2(DEPTH):0]     cnt_nxt_o,
  output logic                       drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & (cnt_q != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
endmodule

module tile_cl_resp_ring #(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int IDX    = 0,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 528
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rsp_en_i,
  input  logic [DATA_W-1:0]           rsp_data_i,
  input  logic [9:0]                  rsp_dst_i,
  input  logic [32:0]                 rsp_addr_i,
  input  logic [11:0]                 rsp_size_i,
  output logic                        rsp_stall_o,
  input  logic [1:0]                  lnk_in_vld_i,
  input  logic [1:0][DATA_W+56:0]     lnk_in_pkt_i,
  output logic [1:0]                  lnk_in_full_o,
  output logic [1:0]                  lnk_out_vld_o,
  output logic [1:0][DATA_W+56:0]     lnk_out_pkt_o,
  input  logic [1:0]                  lnk_out_full_i,
  output logic                        dlv_vld_o,
  output logic [DATA_W-1:0]           dlv_data_o,
  output logic [42:0]                 dlv_addr_o,
  output logic [11:0]                 dlv_size_o,
  input  logic                        dlv_rdy_i,
  output logic                        ovf_err_o
);
  localparam int         PKT_W = DATA_W + 57;
  localparam int         AW    = $clog2(DEPTH);
  localparam int         TX_LO = DATA_W + 2;
  localparam int         TY_LO = DATA_W + 7;
  localparam int         SZ_LO = DATA_W + 12;
  localparam int         AD_LO = DATA_W + 24;
  localparam bit         USE_X = (IDX < 2);
  localparam logic [4:0] MY_X  = 5'(TILE_X);
  localparam logic [4:0] MY_Y  = 5'(TILE_Y);
  localparam logic [4:0] MY_K  = USE_X ? MY_X : MY_Y;
  localparam logic [AW:0] AFULL = (AW+1)'(DEPTH - 2);

  function automatic logic [4:0] coord(input logic [PKT_W-1:0] p);
    return USE_X ? p[TX_LO +: 5] : p[TY_LO +: 5];
  endfunction

  logic             inj_vld_q, inj_vld_d;
  logic [PKT_W-1:0] inj_pkt_q, inj_pkt_d;
  logic [4:0]       inj_c;
  logic [1:0]       inj_tgt, inj_sent, lane_match;
  logic             loop_take, inj_consumed;

  logic [1:0]             pt_push, pt_pop, pt_drop;
  logic [1:0]             dl_push, dl_pop, dl_drop, dl_ne;
  logic [1:0][PKT_W-1:0]  pt_head, dl_head, dl_wdata;
  logic [1:0][AW:0]       pt_cnt, pt_nxt, dl_cnt, dl_nxt;
  logic [1:0]             in_full_q, in_full_d;
  logic                   ovf_q, rr_q, rr_d, gnt;
  logic [PKT_W-1:0]       gnt_head;

  assign inj_c      = coord(inj_pkt_q);
  assign inj_tgt[1] = inj_vld_q & (inj_c > MY_K);
  assign inj_tgt[0] = inj_vld_q & (inj_c < MY_K);

  // Loopback shares delivery FIFO 0 with lane0 and yields to a lane0 match.
  assign loop_take = inj_vld_q & (inj_c == MY_K) & ~lane_match[0] &
                     ((dl_cnt[0] != (AW+1)'(DEPTH)) | dl_pop[0]);
  assign inj_consumed = inj_sent[0] | inj_sent[1] | loop_take;
  assign rsp_stall_o  = inj_vld_q & ~inj_consumed;

  always_comb begin
    inj_vld_d = inj_vld_q;
    inj_pkt_d = inj_pkt_q;
    if (inj_consumed) inj_vld_d = 1'b0;
    if (rsp_en_i && !rsp_stall_o) begin
      inj_vld_d = 1'b1;
      inj_pkt_d = {rsp_addr_i, rsp_size_i, rsp_dst_i[9:5], rsp_dst_i[4:0],
                   !USE_X, USE_X, rsp_data_i};
    end
  end

  assign dl_push[1]  = lane_match[1];
  assign dl_wdata[1] = lnk_in_pkt_i[1];
  assign dl_push[0]  = lane_match[0] | loop_take;
  assign dl_wdata[0] = lane_match[0] ? lnk_in_pkt_i[0] : inj_pkt_q;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign lane_match[i] = lnk_in_vld_i[i] & (coord(lnk_in_pkt_i[i]) == MY_K);
    assign pt_push[i]    = lnk_in_vld_i[i] & ~lane_match[i];
    // Transit traffic always wins the output link over local injection.
    assign pt_pop[i]     = (pt_cnt[i] != '0) & ~lnk_out_full_i[i];
    assign inj_sent[i]   = inj_tgt[i] & (pt_cnt[i] == '0) & ~lnk_out_full_i[i];
    assign lnk_out_vld_o[i] = pt_pop[i] | inj_sent[i];
    assign lnk_out_pkt_o[i] = pt_pop[i]   ? pt_head[i] :
                              inj_sent[i] ? inj_pkt_q  : '0;
    assign dl_ne[i]     = (dl_cnt[i] != '0);
    assign in_full_d[i] = (pt_nxt[i] >= AFULL) | (dl_nxt[i] >= AFULL);

    tile_cl_resp_ring_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_pt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (pt_push[i]),
      .wdata_i   (lnk_in_pkt_i[i]),
      .pop_i     (pt_pop[i]),
      .head_o    (pt_head[i]),
      .cnt_o     (pt_cnt[i]),
      .cnt_nxt_o (pt_nxt[i]),
      .drop_o    (pt_drop[i])
    );

    tile_cl_resp_ring_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_dl (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (dl_push[i]),
      .wdata_i   (dl_wdata[i]),
      .pop_i     (dl_pop[i]),
      .head_o    (dl_head[i]),
      .cnt_o     (dl_cnt[i]),
      .cnt_nxt_o (dl_nxt[i]),
      .drop_o    (dl_drop[i])
    );
  end

  always_comb begin
    gnt = rr_q;
    if (!dl_ne[rr_q]) gnt = ~rr_q;
  end

  assign dlv_vld_o = |dl_ne;
  assign dl_pop[0] = dlv_vld_o & dlv_rdy_i & ~gnt;
  assign dl_pop[1] = dlv_vld_o & dlv_rdy_i & gnt;
  assign rr_d      = (dlv_vld_o & dlv_rdy_i) ? ~gnt : rr_q;
  assign gnt_head  = gnt ? dl_head[1] : dl_head[0];

  assign dlv_data_o = dlv_vld_o ? gnt_head[DATA_W-1:0] : '0;
  assign dlv_size_o = dlv_vld_o ? gnt_head[SZ_LO +: 12] : '0;
  assign dlv_addr_o = dlv_vld_o ? {MY_Y, MY_X, gnt_head[AD_LO +: 33]} : '0;

  assign lnk_in_full_o = in_full_q;
  assign ovf_err_o     = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_vld_q <= 1'b0;
      inj_pkt_q <= '0;
      in_full_q <= '0;
      ovf_q     <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      inj_vld_q <= inj_vld_d;
      inj_pkt_q <= inj_pkt_d;
      in_full_q <= in_full_d;
      ovf_q     <= ovf_q | (|pt_drop) | (|dl_drop);
      rr_q      <= rr_d;
    end
  end
endmodule

`default_nettype wire
